// File: rtl/irq_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package irq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STOP = 3'd1,
        ST_CALL = 3'd2,
        ST_JMP  = 3'd3,
        ST_SERV = 3'd4
    } state_t;

    localparam int CNT_W = 3;

    function automatic int IRQ_ID_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_ctrl_vec_if.sv
// Request lines in, CPU strobes and status out; master is the controller side.
interface irq_ctrl_vec_if
    import irq_pkg::*;
#(
    parameter int N_IRQ  = 8,
    parameter int ADDR_W = 16
) ();

    localparam int ID_W = IRQ_ID_W(N_IRQ);

    logic [N_IRQ-1:0]  irq;
    logic [N_IRQ-1:0]  irq_mask;
    logic [N_IRQ-1:0]  irq_edge;
    logic              glob_en;
    logic              reti;
    logic [ADDR_W-1:0] Addr;
    logic              Call;
    logic              INTjmp;
    logic              intSTOP;
    logic [N_IRQ-1:0]  irq_pending;
    logic              irq_active;
    logic [ID_W-1:0]   irq_active_id;

    modport master (
        input  irq, irq_mask, irq_edge, glob_en, reti,
        output Addr, Call, INTjmp, intSTOP, irq_pending, irq_active, irq_active_id
    );

    modport slave (
        output irq, irq_mask, irq_edge, glob_en, reti,
        input  Addr, Call, INTjmp, intSTOP, irq_pending, irq_active, irq_active_id
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // scan from the top so the lowest set index is the last one written
    always_comb begin
        valid = 1'b0;
        id    = {ID_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            id    = req[i] ? ID_W'(i) : id;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/irq_ctrl_vec.sv
// Vectored interrupt controller: pending latches, fixed-priority pick and
// the STOP/CALL/JMP entry sequence towards the CPU, blocked until reti.
module irq_ctrl_vec
    import irq_pkg::*;
#(
    parameter int               N_IRQ    = 8,
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE = 16'hFFF8,
    parameter int               CALL_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    irq_ctrl_vec_if.master    bus
);

    localparam int ID_W = IRQ_ID_W(N_IRQ);

    logic [N_IRQ-1:0]  irq_q_r;
    logic [N_IRQ-1:0]  pending_r;
    logic [N_IRQ-1:0]  pending_s;
    logic [N_IRQ-1:0]  edge_s;
    logic [N_IRQ-1:0]  clr_s;
    logic [N_IRQ-1:0]  cand_s;
    logic              cand_valid_s;
    logic [ID_W-1:0]   cand_id_s;
    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              capture_s;
    logic [ID_W-1:0]   id_r;
    logic              stop_s, call_s, jmp_s, active_s;
    logic [ADDR_W-1:0] addr_s;
    logic              stop_r, call_r, jmp_r, active_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ID_W-1:0]   active_id_r;

    assign edge_s = bus.irq & ~irq_q_r;
    assign clr_s  = (state_r == ST_JMP) ? ({{(N_IRQ-1){1'b0}}, 1'b1} << id_r)
                                        : {N_IRQ{1'b0}};
    // a fresh edge overrides the service clear so it is never lost
    assign pending_s = (bus.irq_edge & ((pending_r & ~clr_s) | edge_s))
                     | (~bus.irq_edge & bus.irq);
    assign cand_s    = pending_r & bus.irq_mask;

    irq_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_prio (
        .req   (cand_s),
        .valid (cand_valid_s),
        .id    (cand_id_s)
    );

    // next-state and Call-cycle counter
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.glob_en && cand_valid_s) begin
                    state_s   = ST_STOP;
                    capture_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STOP: begin
                state_s = ST_CALL;
                cnt_s   = {CNT_W{1'b0}};
            end
            ST_CALL: begin
                if (cnt_r == CNT_W'(CALL_CYC - 1)) begin
                    state_s = ST_JMP;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_JMP:  state_s = ST_SERV;
            ST_SERV: begin
                if (bus.reti) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SERV;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // strobe decode, registered below so every CPU-facing output is a flop
    always_comb begin
        stop_s   = 1'b0;
        call_s   = 1'b0;
        jmp_s    = 1'b0;
        active_s = 1'b0;
        addr_s   = {ADDR_W{1'b0}};
        case (state_r)
            ST_IDLE: active_s = 1'b0;
            ST_STOP: begin
                stop_s   = 1'b1;
                active_s = 1'b1;
            end
            ST_CALL: begin
                stop_s   = 1'b1;
                call_s   = 1'b1;
                active_s = 1'b1;
            end
            ST_JMP: begin
                stop_s   = 1'b1;
                jmp_s    = 1'b1;
                active_s = 1'b1;
                addr_s   = VEC_BASE + ADDR_W'(id_r);
            end
            ST_SERV: active_s = 1'b1;
            default: active_s = 1'b0;
        endcase
    end

    // state, pending and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            irq_q_r     <= {N_IRQ{1'b0}};
            pending_r   <= {N_IRQ{1'b0}};
            id_r        <= {ID_W{1'b0}};
            stop_r      <= 1'b0;
            call_r      <= 1'b0;
            jmp_r       <= 1'b0;
            active_r    <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            active_id_r <= {ID_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            irq_q_r     <= bus.irq;
            pending_r   <= pending_s;
            id_r        <= capture_s ? cand_id_s : id_r;
            stop_r      <= stop_s;
            call_r      <= call_s;
            jmp_r       <= jmp_s;
            active_r    <= active_s;
            addr_r      <= addr_s;
            active_id_r <= active_s ? id_r : {ID_W{1'b0}};
        end
    end

    assign bus.Addr          = addr_r;
    assign bus.Call          = call_r;
    assign bus.INTjmp        = jmp_r;
    assign bus.intSTOP       = stop_r;
    assign bus.irq_pending   = pending_r;
    assign bus.irq_active    = active_r;
    assign bus.irq_active_id = active_id_r;

endmodule
